// File: rtl/lcd_text_buffer_if.sv
// lcd_text_buffer_if: write/read port bundle between user logic,
// the LCD controller (master) and the text buffer (slave).
interface lcd_text_buffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_cmd;
   logic [7:0] wr_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic       dirty;
   logic       dirty_clr;
   logic [4:0] cursor;

   modport master (
      output wr_valid, wr_cmd, wr_data, rd_addr, dirty_clr,
      input  wr_ready, rd_data, dirty, cursor
   );

   modport slave (
      input  wr_valid, wr_cmd, wr_data, rd_addr, dirty_clr,
      output wr_ready, rd_data, dirty, cursor
   );
endinterface

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 2x16 character store feeding the text LCD controller.
// Define LCD_BUF_SCROLL_EN to scroll line 1 up instead of wrapping.
module lcd_text_buffer #(
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic             clk,
   input  logic             resetn,
   lcd_text_buffer_if.slave bus
);

`ifdef LCD_BUF_SCROLL_EN
   typedef enum logic [1:0] {INIT, IDLE, FILL, SCROLL} state_t;
`else
   typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;
`endif

   state_t     state;
   logic [4:0] idx;
   logic [7:0] mem [32];

   logic       accept;
   logic       put;
   logic       eob;
   logic       set_dirty;
   logic       we0;
   logic       we1;
   logic [4:0] wa0;
   logic [4:0] wa1;
   logic [7:0] wd0;
   logic [7:0] wd1;

   assign accept = bus.wr_valid && bus.wr_ready;
   assign put    = accept && (bus.wr_cmd == 2'b00);
   assign eob    = accept &&
                   (((bus.wr_cmd == 2'b00) && (bus.cursor == 5'd31)) ||
                    ((bus.wr_cmd == 2'b11) && bus.cursor[4]));

   // Buffer write ports and dirty-set events for the current state
   always_comb begin
      we0       = 1'b0;
      wa0       = idx;
      wd0       = FILL_CHAR;
      we1       = 1'b0;
      wa1       = {1'b1, idx[3:0]};
      wd1       = FILL_CHAR;
      set_dirty = 1'b0;
      case (state)
         INIT, FILL: begin
            we0       = 1'b1;
            set_dirty = (idx == 5'd31);
         end
         IDLE: begin
            if (put) begin
               we0       = 1'b1;
               wa0       = bus.cursor;
               wd0       = bus.wr_data;
               set_dirty = 1'b1;
            end
         end
`ifdef LCD_BUF_SCROLL_EN
         SCROLL: begin
            we0       = 1'b1;
            wa0       = {1'b0, idx[3:0]};
            wd0       = mem[{1'b1, idx[3:0]}];
            we1       = 1'b1;
            set_dirty = (idx == 5'd15);
         end
`endif
         default: ;
      endcase
   end

   // Character storage, deliberately without reset
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   // Control FSM, cursor, dirty flag and registered read port
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= INIT;
         idx          <= '0;
         bus.wr_ready <= 1'b0;
         bus.rd_data  <= 8'h00;
         bus.dirty    <= 1'b0;
         bus.cursor   <= '0;
      end else begin
         bus.rd_data <= mem[bus.rd_addr];
         if (set_dirty)
            bus.dirty <= 1'b1;
         else if (bus.dirty_clr)
            bus.dirty <= 1'b0;
         case (state)
            INIT, FILL: begin
               idx <= idx + 5'd1;
               if (idx == 5'd31) begin
                  state        <= IDLE;
                  bus.wr_ready <= 1'b1;
               end
            end
            IDLE: begin
               if (accept) begin
                  unique case (bus.wr_cmd)
                     2'b00: bus.cursor <= bus.cursor + 5'd1;
                     2'b01: bus.cursor <= bus.wr_data[4:0];
                     2'b10: begin
                        bus.cursor   <= '0;
                        state        <= FILL;
                        bus.wr_ready <= 1'b0;
                        idx          <= '0;
                     end
                     2'b11: bus.cursor <= 5'd16;
                  endcase
                  if (eob) begin
`ifdef LCD_BUF_SCROLL_EN
                     bus.cursor   <= 5'd16;
                     state        <= SCROLL;
                     bus.wr_ready <= 1'b0;
                     idx          <= '0;
`else
                     bus.cursor   <= '0;
`endif
                  end
               end
            end
`ifdef LCD_BUF_SCROLL_EN
            SCROLL: begin
               idx <= idx + 5'd1;
               if (idx == 5'd15) begin
                  state        <= IDLE;
                  bus.wr_ready <= 1'b1;
                  idx          <= '0;
               end
            end
`endif
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed stimulus for lcd_text_buffer with a
// per-cycle comparison against a behavioural model of the buffer.
module tb_lcd_text_buffer;
   localparam logic [7:0] FC = 8'h20;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   lcd_text_buffer_if bus();

   lcd_text_buffer dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] m [32];
   int         busy = 0;
   logic [4:0] mcur = '0;
   logic       mdirty = 1'b0;
   logic [7:0] mrd = '0;
   logic       rd_ok = 1'b0;
   logic       mvalid = 1'b0;
   logic       mset;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic model_eob();
`ifdef LCD_BUF_SCROLL_EN
      for (int k = 0; k < 16; k++) begin
         m[k]      = m[16+k];
         m[16+k]   = FC;
      end
      mcur = 5'd16;
      busy = 16;
`else
      mcur = 5'd0;
`endif
   endtask

   // Model: commands take effect whole at acceptance; busy counts the
   // cycles the buffer refuses requests afterwards.
   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         foreach (m[i]) m[i] = FC;
         busy   = 32;
         mcur   = '0;
         mdirty = 1'b0;
         rd_ok  = 1'b0;
         mvalid = 1'b1;
      end else begin
         rd_ok = (busy == 0);
         mrd   = m[bus.rd_addr];
         mset  = 1'b0;
         if (busy > 0) begin
            busy--;
            mset = (busy == 0);
         end else if (bus.wr_valid) begin
            case (bus.wr_cmd)
               2'b00: begin
                  m[mcur] = bus.wr_data;
                  mset = 1'b1;
                  if (mcur == 5'd31) model_eob();
                  else mcur = mcur + 5'd1;
               end
               2'b01: mcur = bus.wr_data[4:0];
               2'b10: begin
                  mcur = '0;
                  foreach (m[i]) m[i] = FC;
                  busy = 32;
               end
               default: begin
                  if (mcur < 5'd16) mcur = 5'd16;
                  else model_eob();
               end
            endcase
         end
         if (mset) mdirty = 1'b1;
         else if (bus.dirty_clr) mdirty = 1'b0;
      end
   end

   // Compare DUT outputs with the model on every falling edge
   initial forever begin
      @(negedge clk);
      if (resetn && mvalid) begin
         chk("cyc_ready", {31'd0, bus.wr_ready}, {31'd0, busy == 0});
         chk("cyc_cursor", {27'd0, bus.cursor}, {27'd0, mcur});
         chk("cyc_dirty", {31'd0, bus.dirty}, {31'd0, mdirty});
         if (rd_ok)
            chk("cyc_rd_data", {24'd0, bus.rd_data}, {24'd0, mrd});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.wr_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.wr_ready) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: wr_ready=0 required 1 after %0d cycles", n);
      end
   endtask

   task automatic cmd(input logic [1:0] c, input logic [7:0] d);
      wait_ready();
      bus.wr_valid = 1'b1;
      bus.wr_cmd   = c;
      bus.wr_data  = d;
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      bus.rd_addr = a;
      tick();
      d = bus.rd_data;
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (!bus.wr_ready && n < 200) begin
         n++;
         tick();
      end
   endtask

   logic [7:0] d;
   int         n;

   initial begin
      bus.wr_valid  = 1'b0;
      bus.wr_cmd    = 2'b00;
      bus.wr_data   = 8'h00;
      bus.rd_addr   = 5'd0;
      bus.dirty_clr = 1'b0;
      resetn        = 1'b0;
      repeat (3) tick();
      chk("rst_ready", {31'd0, bus.wr_ready}, 0);
      chk("rst_dirty", {31'd0, bus.dirty}, 0);
      chk("rst_cursor", {27'd0, bus.cursor}, 0);
      chk("rst_rd_data", {24'd0, bus.rd_data}, 0);

      resetn = 1'b1;
      count_low(n);
      chk("init_ready_low", n, 32);
      for (int a = 0; a < 32; a++) begin
         rd(5'(a), d);
         chk("init_buf", {24'd0, d}, 32'h20);
      end
      chk("init_dirty", {31'd0, bus.dirty}, 1);
      chk("init_cursor", {27'd0, bus.cursor}, 0);

      bus.dirty_clr = 1'b1;
      tick();
      bus.dirty_clr = 1'b0;
      chk("dirty_clr", {31'd0, bus.dirty}, 0);
      wait_ready();
      bus.wr_valid = 1'b1;
      bus.wr_cmd   = 2'b00;
      bus.wr_data  = 8'h48;
      tick();
      chk("b2b_ready", {31'd0, bus.wr_ready}, 1);
      bus.wr_data  = 8'h69;
      tick();
      bus.wr_valid = 1'b0;
      rd(5'd0, d);
      chk("put_addr0", {24'd0, d}, 32'h48);
      rd(5'd1, d);
      chk("put_addr1", {24'd0, d}, 32'h69);
      chk("put_cursor", {27'd0, bus.cursor}, 2);
      chk("put_dirty", {31'd0, bus.dirty}, 1);
      bus.dirty_clr = 1'b1;
      tick();
      bus.dirty_clr = 1'b0;
      chk("dirty_clr2", {31'd0, bus.dirty}, 0);
      wait_ready();
      bus.wr_valid  = 1'b1;
      bus.wr_cmd    = 2'b00;
      bus.wr_data   = 8'h21;
      bus.dirty_clr = 1'b1;
      tick();
      bus.wr_valid  = 1'b0;
      bus.dirty_clr = 1'b0;
      chk("set_wins", {31'd0, bus.dirty}, 1);

`ifndef LCD_BUF_SCROLL_EN
      cmd(2'b01, 8'd31);
      cmd(2'b00, 8'h41);
      rd(5'd31, d);
      chk("wrap_addr31", {24'd0, d}, 32'h41);
      chk("wrap_cursor", {27'd0, bus.cursor}, 0);
`endif

      cmd(2'b01, 8'd5);
      cmd(2'b11, 8'h00);
      chk("nl_line0", {27'd0, bus.cursor}, 16);
`ifndef LCD_BUF_SCROLL_EN
      cmd(2'b11, 8'h00);
      chk("nl_line1", {27'd0, bus.cursor}, 0);
`endif

      cmd(2'b01, 8'd0);
`ifdef LCD_BUF_SCROLL_EN
      for (int i = 0; i < 31; i++) cmd(2'b00, 8'h2A);
`else
      for (int i = 0; i < 32; i++) cmd(2'b00, 8'h2A);
`endif
      rd(5'd5, d);
      chk("star_addr5", {24'd0, d}, 32'h2A);
      rd(5'd30, d);
      chk("star_addr30", {24'd0, d}, 32'h2A);
      cmd(2'b10, 8'h00);
      count_low(n);
      chk("clr_ready_low", n, 32);
      for (int a = 0; a < 32; a++) begin
         rd(5'(a), d);
         chk("clr_buf", {24'd0, d}, 32'h20);
      end
      chk("clr_cursor", {27'd0, bus.cursor}, 0);

      cmd(2'b00, 8'h55);
      cmd(2'b10, 8'h00);
      repeat (10) tick();
      resetn = 1'b0;
      tick();
      chk("mid_rst_ready", {31'd0, bus.wr_ready}, 0);
      resetn = 1'b1;
      count_low(n);
      chk("mid_rst_ready_low", n, 32);
      rd(5'd0, d);
      chk("mid_rst_addr0", {24'd0, d}, 32'h20);
      chk("mid_rst_dirty", {31'd0, bus.dirty}, 1);

`ifdef LCD_BUF_SCROLL_EN
      cmd(2'b01, 8'd16);
      for (int i = 0; i < 15; i++) cmd(2'b00, 8'(8'h30 + i));
      cmd(2'b00, 8'h58);
      count_low(n);
      chk("scroll_ready_low", n, 16);
      for (int a = 0; a < 15; a++) begin
         rd(5'(a), d);
         chk("scroll_line0", {24'd0, d}, 32'h30 + a);
      end
      rd(5'd15, d);
      chk("scroll_addr15", {24'd0, d}, 32'h58);
      for (int a = 16; a < 32; a++) begin
         rd(5'(a), d);
         chk("scroll_line1", {24'd0, d}, 32'h20);
      end
      chk("scroll_cursor", {27'd0, bus.cursor}, 16);
`endif

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
